eval_sequencer: RTL
===================

// Module: eval_sequencer
// PURPOSE
//  Custom-instruction front end that sequences the function_evaluation datapath and owns the running sum.
//  GO queues an operand pair. Queued pairs are issued to the pipelined datapath under credit flow control.
//  Returned terms are folded into a 32-bit float sum by an external multi-cycle FP adder.
//  READ returns the fully drained sum. CLEAR zeroes the sum after a drain.
// PARAMETERS
//  FLT_DATA_WIDTH   32  width of float operands, terms and sum
//  N_WIDTH          2   command field width
//  OP_FIFO_DEPTH    4   operand-pair queue depth (power of 2)
//  TERM_FIFO_DEPTH  4   returned-term buffer depth; also the issue credit limit
//  CNT_WIDTH        3   width of occupancy and in-flight counters; must hold 0..max depth
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   asynchronous reset, active-low
//  clk_en    in   1   command qualifier; start is ignored while low
//  start     in   1   command strobe, one cycle
//  n         in   2   command: 0=CLEAR, 1=GO, 2=READ, 3=reserved
//  x_one     in   32  operand A; sampled on GO
//  x_two     in   32  operand B; sampled on GO
//  result    out  32  sum on READ, else 0; valid while done=1
//  done      out  1   one-cycle command completion pulse
//  dp_ready  in   1   datapath can accept a pair this cycle
//  dp_start  out  1   issue strobe to datapath
//  dp_x_one  out  32  issued operand A
//  dp_x_two  out  32  issued operand B
//  dp_valid  in   1   datapath term valid, one-cycle pulse
//  dp_term   in   32  datapath term
//  add_start out  1   adder launch strobe
//  add_a     out  32  adder operand: current sum
//  add_b     out  32  adder operand: term
//  add_done  in   1   adder result valid, one-cycle pulse
//  add_sum   in   32  adder result
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, sum=0, both FIFOs empty, in_flight=0, FSMs idle. Reset mid-operation discards all queued and in-flight work.
//  Command FSM states: C_IDLE, C_PUSH, C_DRAIN, C_DONE. start is sampled only in C_IDLE with clk_en=1; it is ignored elsewhere.
//   GO:    C_IDLE->C_PUSH. The pair is written to the op FIFO on the first C_PUSH cycle with op FIFO not full, then ->C_DONE.
//          With space available, done rises 2 cycles after start. When full, C_PUSH holds until a pop frees a slot.
//   READ:  C_IDLE->C_DRAIN. Stays there until drained = op FIFO empty & in_flight=0 & term FIFO empty & adder idle; then ->C_DONE with result<=sum.
//   CLEAR: identical drain, then sum<=0 and result<=0, ->C_DONE.
//   n=3:   ->C_DONE with result=0; no other effect.
//   C_DONE: done=1 for exactly one cycle, ->C_IDLE. result clears to 0 the cycle after done.
//  Issue: dp_start=1 in any cycle with op FIFO non-empty & dp_ready=1 & (in_flight + term_count) < TERM_FIFO_DEPTH.
//   dp_x_one and dp_x_two present the FIFO head that same cycle, and the head is popped.
//   The credit rule guarantees the term FIFO never overflows. No issue while rst=0.
//  in_flight: +1 on dp_start, -1 on dp_valid; both in one cycle leaves it unchanged.
//   A dp_valid with in_flight=0 is a protocol error: the term is dropped and the counter does not underflow.
//  Term FIFO: push on dp_valid, pop on accumulator launch. Simultaneous push and pop keeps the count; a push on empty may not launch in the same cycle.
//  Accumulator FSM: A_IDLE, A_WAIT.
//   A_IDLE with term FIFO non-empty: add_start=1 for 1 cycle, add_a=sum, add_b=head, pop, ->A_WAIT.
//   A_WAIT on add_done: sum<=add_sum, ->A_IDLE.
//   Exactly one add is outstanding at a time. add_a and add_b hold their values until add_done.
//  Issue and accumulation run independently of clk_en and of the command FSM, so GO returns before its term is summed.
//  CLEAR and READ order after all earlier GOs, because the drain includes every queued pair.
//  Float arithmetic is done entirely by the external adder; this block never inspects float fields.
// TESTING
//  Models: datapath term = 1.0 (0x3F800000) at 5-cycle latency with dp_ready=1; adder is exact with 3-cycle latency.
//  Reset, then READ -> done 2 cycles after start (immediate drain), result=0x00000000.
//  3x GO then READ -> READ done only after the 3rd add_done; result=0x40400000 (3.0).
//  dp_ready=0 and 5x GO -> first 4 done after 2 cycles each; 5th done withheld until dp_ready=1 frees a slot.
//  Adder latency 20 and 8x GO -> in_flight+term_count never exceeds 4; READ returns 0x41000000 (8.0).
//  2x GO, CLEAR, 1x GO, READ -> result=0x3F800000; n=3 gives done with result 0 and sum unchanged.
//  rst low while an add is outstanding -> all outputs 0 at once; a following READ returns 0.

Source files
------------

// File: rtl/eval_sequencer.sv
// Command front end for the function-evaluation datapath; owns the running float sum.
// Latency: GO done 2 cycles after start when the op queue has room; READ/CLEAR done 2 cycles after drain.
// Backpressure: GO stalls on a full op queue; issue is credit-limited by term-buffer depth; one add outstanding.

module eval_sequencer_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_vld,
    output logic                 wr_rdy,
    input  logic [WIDTH-1:0]     wr_dat,
    output logic                 rd_vld,
    input  logic                 rd_rdy,
    output logic [WIDTH-1:0]     rd_dat,
    output logic [CNT_WIDTH-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != CNT_WIDTH'(DEPTH));
    assign rd_vld = (count != '0);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module eval_sequencer #(
    parameter int FLT_DATA_WIDTH  = 32,
    parameter int N_WIDTH         = 2,
    parameter int OP_FIFO_DEPTH   = 4,
    parameter int TERM_FIFO_DEPTH = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      start,
    input  logic [N_WIDTH-1:0]        n,
    input  logic [FLT_DATA_WIDTH-1:0] x_one,
    input  logic [FLT_DATA_WIDTH-1:0] x_two,
    output logic [FLT_DATA_WIDTH-1:0] result,
    output logic                      done,
    input  logic                      dp_ready,
    output logic                      dp_start,
    output logic [FLT_DATA_WIDTH-1:0] dp_x_one,
    output logic [FLT_DATA_WIDTH-1:0] dp_x_two,
    input  logic                      dp_valid,
    input  logic [FLT_DATA_WIDTH-1:0] dp_term,
    output logic                      add_start,
    output logic [FLT_DATA_WIDTH-1:0] add_a,
    output logic [FLT_DATA_WIDTH-1:0] add_b,
    input  logic                      add_done,
    input  logic [FLT_DATA_WIDTH-1:0] add_sum
);
    localparam int FW = FLT_DATA_WIDTH;
    localparam logic [N_WIDTH-1:0] CMD_CLEAR = N_WIDTH'(0);
    localparam logic [N_WIDTH-1:0] CMD_GO    = N_WIDTH'(1);
    localparam logic [N_WIDTH-1:0] CMD_READ  = N_WIDTH'(2);

    typedef enum logic [1:0] {C_IDLE, C_PUSH, C_DRAIN, C_DONE} cmd_state_t;
    typedef enum logic {A_IDLE, A_WAIT} acc_state_t;

    cmd_state_t c_state, c_next;
    acc_state_t a_state, a_next;

    logic [FW-1:0]        op_a, op_b, sum, add_a_q, add_b_q;
    logic                 is_clear;
    logic [CNT_WIDTH-1:0] in_flight;

    logic                 op_wr_vld, op_wr_rdy, op_rd_vld;
    logic [2*FW-1:0]      op_rd_dat;
    logic [CNT_WIDTH-1:0] op_count;
    logic                 term_wr_rdy, term_rd_vld, term_accept;
    logic [FW-1:0]        term_rd_dat;
    logic [CNT_WIDTH-1:0] term_count;
    logic                 credit_ok, launch, drained, cmd_take;

    eval_sequencer_fifo #(.WIDTH(2*FW), .DEPTH(OP_FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)) u_op_fifo (
        .clk(clk), .rst_n(rst),
        .wr_vld(op_wr_vld), .wr_rdy(op_wr_rdy), .wr_dat({op_a, op_b}),
        .rd_vld(op_rd_vld), .rd_rdy(dp_start), .rd_dat(op_rd_dat), .count(op_count)
    );

    eval_sequencer_fifo #(.WIDTH(FW), .DEPTH(TERM_FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)) u_term_fifo (
        .clk(clk), .rst_n(rst),
        .wr_vld(term_accept), .wr_rdy(term_wr_rdy), .wr_dat(dp_term),
        .rd_vld(term_rd_vld), .rd_rdy(launch), .rd_dat(term_rd_dat), .count(term_count)
    );

    // Credits cover both in-flight terms and buffered ones, so the term FIFO can never overflow.
    assign credit_ok   = ({1'b0, in_flight} + {1'b0, term_count}) < (CNT_WIDTH+1)'(TERM_FIFO_DEPTH);
    assign dp_start    = op_rd_vld && dp_ready && credit_ok;
    assign dp_x_one    = dp_start ? op_rd_dat[2*FW-1:FW] : '0;
    assign dp_x_two    = dp_start ? op_rd_dat[FW-1:0]    : '0;
    assign term_accept = dp_valid && (in_flight != '0) && term_wr_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_flight <= '0;
        end else begin
            case ({dp_start, term_accept})
                2'b10:   in_flight <= in_flight + CNT_WIDTH'(1);
                2'b01:   in_flight <= in_flight - CNT_WIDTH'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    assign launch    = (a_state == A_IDLE) && term_rd_vld;
    assign add_start = launch;
    assign add_a     = launch ? sum         : ((a_state == A_WAIT) ? add_a_q : '0);
    assign add_b     = launch ? term_rd_dat : ((a_state == A_WAIT) ? add_b_q : '0);

    always_comb begin
        a_next = a_state;
        case (a_state)
            A_IDLE:  if (launch)   a_next = A_WAIT;
            A_WAIT:  if (add_done) a_next = A_IDLE;
            default: a_next = A_IDLE;
        endcase
    end

    assign drained  = (op_count == '0) && (in_flight == '0) && !term_rd_vld && (a_state == A_IDLE);
    assign cmd_take = (c_state == C_IDLE) && clk_en && start;
    assign done     = (c_state == C_DONE);

    always_comb begin
        c_next    = c_state;
        op_wr_vld = 1'b0;
        case (c_state)
            C_IDLE: begin
                if (cmd_take) begin
                    if (n == CMD_GO)                            c_next = C_PUSH;
                    else if (n == CMD_READ || n == CMD_CLEAR)   c_next = C_DRAIN;
                    else                                        c_next = C_DONE;
                end
            end
            C_PUSH: begin
                op_wr_vld = 1'b1;
                if (op_wr_rdy) c_next = C_DONE;
            end
            C_DRAIN: if (drained) c_next = C_DONE;
            C_DONE:  c_next = C_IDLE;
            default: c_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_state  <= C_IDLE;
            a_state  <= A_IDLE;
            op_a     <= '0;
            op_b     <= '0;
            is_clear <= 1'b0;
            result   <= '0;
            sum      <= '0;
            add_a_q  <= '0;
            add_b_q  <= '0;
        end else begin
            c_state <= c_next;
            a_state <= a_next;
            if (cmd_take) begin
                op_a     <= x_one;
                op_b     <= x_two;
                is_clear <= (n == CMD_CLEAR);
            end
            if (c_state == C_DRAIN && drained)
                result <= is_clear ? '0 : sum;
            else if (c_state == C_DONE)
                result <= '0;
            // The drain guarantees the adder is idle, so CLEAR never races an add result.
            if (c_state == C_DRAIN && drained && is_clear)
                sum <= '0;
            else if (a_state == A_WAIT && add_done)
                sum <= add_sum;
            if (launch) begin
                add_a_q <= sum;
                add_b_q <= term_rd_dat;
            end
        end
    end
endmodule
